// File: rtl/dmem_responder.sv
// dmem_responder: RV32I MEM-stage data memory with valid/ready request/response and wait states.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned H/HU/W accesses as errors instead of force-aligning them.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, err_q, err_d, access;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q, rdata_q, rdata_d, word, lval, wd, wword, bm;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [3:0]        be;
    logic [31:0]       mem [0:2**(ADDR_W-2)-1];
    assign req_ready = state_q == IDLE && !reset;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign access    = state_q == WAIT && cnt_q == 4'd0;
    assign word      = mem[addr_q[ADDR_W-1:2]];
    assign byte_v    = 8'(word >> {addr_q[1:0], 3'b000});
    assign half_v    = addr_q[1] ? word[31:16] : word[15:0];
    always_comb begin
        lval = f3_q[1:0] == 2'b00 ? {{24{byte_v[7] & ~f3_q[2]}}, byte_v}
             : f3_q[1:0] == 2'b01 ? {{16{half_v[15] & ~f3_q[2]}}, half_v} : word;
        be = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
           : f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}}
           : f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
        bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wword = (wd & bm) | (word & ~bm);
        err_d = f3_q == 3'b011 || f3_q[2:1] == 2'b11 || (we_q && f3_q[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
        err_d = err_d || (f3_q[1:0] == 2'b01 && addr_q[0]) || (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`endif
        rdata_d = (we_q || err_d) ? 32'd0 : lval;
        state_d = state_q == IDLE ? (req_valid ? WAIT : IDLE)
                : state_q == WAIT ? (cnt_q == 4'd0 ? RESP : WAIT)
                : (rsp_ready ? IDLE : RESP);
        cnt_d = (state_q == IDLE && req_valid) ? 4'(WAIT_CYCLES)
              : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (access) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end
    // Request capture and storage are not reset; a write only lands if reset is low at the access edge.
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
        end
        if (!reset && access && we_q && !err_d)
            mem[addr_q[ADDR_W-1:2]] <= wword;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I pipeline's MEM stage. It accepts one load or store request at a time over a valid/ready handshake, models configurable wait states, and applies RISC-V byte, half and word access rules using funct3. It returns read data or a store acknowledge over a second valid/ready channel, which lets the pipeline stall on memory latency instead of relying on single-cycle access. Storage is 2^ADDR_W bytes, organized as 32-bit words.

## Interface
Parameters:
- ADDR_W, 10, byte-address width; depth = 2^(ADDR_W-2) words
- WAIT_CYCLES, 2, wait states between acceptance and access; legal range 0..15

Ports:
- clk  in  1  system clock
- reset  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rsp_valid  out  1  response present
- rsp_ready  in  1  pipeline accepts the response
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_err  out  1  illegal or misaligned access; qualified by rsp_valid

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready = 1.
  - On req_valid && req_ready, capture we, addr, wdata and funct3.
  - Load wait counter with WAIT_CYCLES and go to WAIT.
- WAIT: req_ready = 0.
  - If counter != 0, decrement it.
  - If counter == 0, perform the access, register rdata and err, and go to RESP.
- RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE.
  - A new request is never accepted in the RESP cycle.
- Loads: select the byte or half from the word using addr[1:0].
  - B and H are sign-extended; BU and HU are zero-extended.
- Stores: the byte lane(s) are taken from wdata[7:0] or wdata[15:0] and written at addr[1:0]. Other lanes are unchanged.
  - Stores with funct3 100 or 101 are illegal.
- Illegal funct3 (011, 110, 111, or a store with 1xx): rsp_err = 1, no write, rsp_rdata = 0.
- Memory contents are not reset. Reset clears only the FSM, counter and output registers.

## Timing
- A request accepted at edge k is accessed at edge k+1+WAIT_CYCLES. rsp_valid is high from that edge onward, so latency is WAIT_CYCLES+1 cycles.
- Minimum spacing between accepted requests is WAIT_CYCLES+3 cycles when rsp_ready is held high.
- Reset values:
  - req_ready = 0 while reset is asserted, 1 in the first cycle after deassertion.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, state = IDLE, counter = 0.
- Reset during WAIT: the pending store is dropped and memory is unchanged. Reset during RESP: the response is discarded.
- req_valid while not in IDLE is ignored; the requester must hold it until it sees req_ready.
- rsp_ready asserted outside RESP has no effect.
- WAIT_CYCLES = 0: WAIT lasts exactly one cycle.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - H/HU with addr[0] = 1, or W with addr[1:0] != 0, sets rsp_err = 1.
  - No write occurs and rsp_rdata = 0.
- Not defined:
  - Misalignment is never an error.
  - H/HU ignores addr[0]; W ignores addr[1:0], so the access is forced down to natural alignment.

## Test plan
- SW 0x010 = 0xDEADBEEF, then LW 0x010 (WAIT_CYCLES = 2) -> rsp_rdata = 0xDEADBEEF; rsp_valid rises 3 cycles after acceptance; rsp_err = 0.
- SB 0x013 = 0x00000080, then:
  - LB 0x013 -> 0xFFFFFF80
  - LBU 0x013 -> 0x00000080
  - LW 0x010 -> 0x80ADBEEF
- SH 0x022 = 0x1234ABCD, then:
  - LH 0x022 -> 0xFFFFABCD
  - LHU 0x022 -> 0x0000ABCD
  - LW 0x020 -> 0xABCD0000, given the word was previously zeroed
- Backpressure: hold rsp_ready = 0 for 5 cycles during RESP -> rsp_valid, rsp_rdata and rsp_err stay constant and req_ready = 0. On the first cycle with rsp_ready = 1, FSM returns to IDLE and req_ready = 1 on the next cycle.
- LW 0x011 with 0x010 = 0xDEADBEEF:
  - With the macro -> rsp_err = 1, rsp_rdata = 0.
  - Without the macro -> rsp_rdata = 0xDEADBEEF, rsp_err = 0.
  - funct3 = 011 load -> rsp_err = 1 in both builds.
- Preload 0x030 = 0x11111111. Issue SW 0x030 = 0x00000055 and assert reset for one cycle during WAIT -> rsp_valid = 0 and req_ready = 1 after reset; a following LW 0x030 returns 0x11111111.
